// File: rtl/dest_tag_queue_mc.sv
// dest_tag_queue_mc: per-channel return-destination queues ({tag,dst,vc}) between request and reply NoC translators.
// Ports: clk/preset_full (async active-high reset); push side i_ch_in/i_dst_in/i_vc_in/i_tag_in/i_valid_in with
// per-channel i_ready_out (not almost full); pop/peek side o_rd_ch_in/o_valid_in with show-ahead head data
// o_dst_out/o_vc_out/o_tag_out; per-channel o_empty_out and packed o_count_out; sticky o_overflow_out/o_underflow_out.
module dest_tag_queue_mc #(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_TAG        = 8,
  parameter int DEPTH            = 12,
  parameter int NUM_CH           = 2,
  parameter int AFULL_MARGIN     = 2,
  parameter bit OVF_FATAL        = 1'b1,
  localparam int CH_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        preset_full,
  input  logic [CH_W-1:0]             i_ch_in,
  input  logic [ADDRESS_WIDTH-1:0]    i_dst_in,
  input  logic [VC_ADDRESS_WIDTH-1:0] i_vc_in,
  input  logic [WIDTH_TAG-1:0]        i_tag_in,
  input  logic                        i_valid_in,
  output logic [NUM_CH-1:0]           i_ready_out,
  input  logic [CH_W-1:0]             o_rd_ch_in,
  input  logic                        o_valid_in,
  output logic [ADDRESS_WIDTH-1:0]    o_dst_out,
  output logic [VC_ADDRESS_WIDTH-1:0] o_vc_out,
  output logic [WIDTH_TAG-1:0]        o_tag_out,
  output logic [NUM_CH-1:0]           o_empty_out,
  output logic [NUM_CH*CNT_W-1:0]     o_count_out,
  output logic                        o_overflow_out,
  output logic                        o_underflow_out
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int W     = WIDTH_TAG + ADDRESS_WIDTH + VC_ADDRESS_WIDTH;
  logic [W-1:0]     mem_q    [NUM_CH][DEPTH];
  logic [PTR_W-1:0] rd_ptr_q [NUM_CH];
  logic [PTR_W-1:0] rd_ptr_d [NUM_CH];
  logic [PTR_W-1:0] wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0] wr_ptr_d [NUM_CH];
  logic [CNT_W-1:0] count_q  [NUM_CH];
  logic [CNT_W-1:0] count_d  [NUM_CH];
  logic             ovf_q, ovf_d, unf_q, unf_d, ovf_now, unf_now;
  logic [NUM_CH-1:0] push_acc, pop_acc;
  logic [W-1:0]     head;
  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return p == PTR_W'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // A push into a full channel is still accepted when the same channel pops this cycle.
  // An out-of-range channel select matches no channel, so it falls out as overflow/underflow.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      pop_acc[c]  = o_valid_in && int'(o_rd_ch_in) == c && count_q[c] != '0;
      push_acc[c] = i_valid_in && int'(i_ch_in) == c && (count_q[c] != CNT_W'(DEPTH) || pop_acc[c]);
      rd_ptr_d[c] = pop_acc[c] ? inc(rd_ptr_q[c]) : rd_ptr_q[c];
      wr_ptr_d[c] = push_acc[c] ? inc(wr_ptr_q[c]) : wr_ptr_q[c];
      count_d[c]  = count_q[c] + CNT_W'(push_acc[c]) - CNT_W'(pop_acc[c]);
    end
    ovf_now = i_valid_in && !(|push_acc);
    unf_now = o_valid_in && !(|pop_acc);
    ovf_d   = ovf_q | ovf_now;
    unf_d   = unf_q | unf_now;
  end
  always_ff @(posedge clk or posedge preset_full) begin
    if (preset_full) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rd_ptr_q[c] <= '0;
        wr_ptr_q[c] <= '0;
        count_q[c]  <= '0;
      end
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        rd_ptr_q[c] <= rd_ptr_d[c];
        wr_ptr_q[c] <= wr_ptr_d[c];
        count_q[c]  <= count_d[c];
      end
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  // Storage is not reset; stale entries are never observable because reads are gated by count.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++)
      if (push_acc[c]) mem_q[c][wr_ptr_q[c]] <= {i_tag_in, i_dst_in, i_vc_in};
  end
  always_comb begin
    o_count_out = '0;
    o_empty_out = '0;
    i_ready_out = '0;
    head        = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      o_count_out[c*CNT_W +: CNT_W] = count_q[c];
      o_empty_out[c] = count_q[c] == '0;
      i_ready_out[c] = count_q[c] < CNT_W'(DEPTH - AFULL_MARGIN);
      if (int'(o_rd_ch_in) == c && count_q[c] != '0) head = mem_q[c][rd_ptr_q[c]];
    end
  end
  assign {o_tag_out, o_dst_out, o_vc_out} = head;
  assign o_overflow_out  = ovf_q;
  assign o_underflow_out = unf_q;
  // An overflow means DEPTH is undersized for the slave's outstanding-reply latency.
  assert property (@(posedge clk) disable iff (preset_full) !(OVF_FATAL && ovf_now))
    else $fatal(1, "dest_tag_queue_mc: push overflow, DEPTH too small for slave latency");
endmodule

// File: tb/tb_dest_tag_queue_mc.sv
// tb_dest_tag_queue_mc: directed and random checks of dest_tag_queue_mc against a queue-based model.
module tb_dest_tag_queue_mc;
  localparam int DEPTH = 12, NUM_CH = 2, AFM = 2, CH_W = 1, CNT_W = 4, W = 13;
  logic clk = 0, preset_full = 0;
  logic [CH_W-1:0] i_ch_in = '0, o_rd_ch_in = '0;
  logic [3:0] i_dst_in = '0, o_dst_out;
  logic [0:0] i_vc_in = '0, o_vc_out;
  logic [7:0] i_tag_in = '0, o_tag_out;
  logic i_valid_in = 0, o_valid_in = 0, o_overflow_out, o_underflow_out;
  logic [NUM_CH-1:0] i_ready_out, o_empty_out;
  logic [NUM_CH*CNT_W-1:0] o_count_out;
  int checks = 0, errors = 0;
  logic [W-1:0] mq [NUM_CH][$];
  bit m_ovf = 0, m_unf = 0;
  always #5 clk = ~clk;
  dest_tag_queue_mc #(.ADDRESS_WIDTH(4), .VC_ADDRESS_WIDTH(1), .WIDTH_TAG(8), .DEPTH(DEPTH),
    .NUM_CH(NUM_CH), .AFULL_MARGIN(AFM), .OVF_FATAL(1'b0)) dut (
    .clk(clk), .preset_full(preset_full), .i_ch_in(i_ch_in), .i_dst_in(i_dst_in), .i_vc_in(i_vc_in),
    .i_tag_in(i_tag_in), .i_valid_in(i_valid_in), .i_ready_out(i_ready_out), .o_rd_ch_in(o_rd_ch_in),
    .o_valid_in(o_valid_in), .o_dst_out(o_dst_out), .o_vc_out(o_vc_out), .o_tag_out(o_tag_out),
    .o_empty_out(o_empty_out), .o_count_out(o_count_out), .o_overflow_out(o_overflow_out),
    .o_underflow_out(o_underflow_out));
  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  // Reference: a plain queue per channel; pop happens before push so a full channel can swap an entry.
  always @(posedge clk or posedge preset_full) begin
    int pc, rc;
    bit pop_ok, push_ok;
    if (preset_full) begin
      for (int c = 0; c < NUM_CH; c++) mq[c].delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      pc = int'(i_ch_in);
      rc = int'(o_rd_ch_in);
      pop_ok  = o_valid_in && rc < NUM_CH && mq[rc].size() > 0;
      push_ok = i_valid_in && pc < NUM_CH && (mq[pc].size() < DEPTH || (pop_ok && rc == pc));
      if (o_valid_in && !pop_ok) m_unf = 1;
      if (i_valid_in && !push_ok) m_ovf = 1;
      if (pop_ok) void'(mq[rc].pop_front());
      if (push_ok) mq[pc].push_back({i_tag_in, i_dst_in, i_vc_in});
    end
  end
  always @(negedge clk) begin
    int s;
    logic [W-1:0] h;
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("count%0d", c), 32'(o_count_out[c*CNT_W +: CNT_W]), mq[c].size());
      check($sformatf("empty%0d", c), 32'(o_empty_out[c]), 32'(mq[c].size() == 0));
      check($sformatf("ready%0d", c), 32'(i_ready_out[c]), 32'(mq[c].size() < DEPTH - AFM));
    end
    check("overflow", 32'(o_overflow_out), 32'(m_ovf));
    check("underflow", 32'(o_underflow_out), 32'(m_unf));
    s = int'(o_rd_ch_in);
    h = (s < NUM_CH && mq[s].size() > 0) ? mq[s][0] : '0;
    check("head", 32'({o_tag_out, o_dst_out, o_vc_out}), 32'(h));
  end
  task automatic step(input bit pv, input int pch, input logic [7:0] tag, input logic [3:0] dst,
                      input bit rv, input int rch);
    i_valid_in = pv;
    i_ch_in    = CH_W'(pch);
    i_tag_in   = tag;
    i_dst_in   = dst;
    i_vc_in    = tag[0];
    o_valid_in = rv;
    o_rd_ch_in = CH_W'(rch);
    @(posedge clk);
    #1;
    i_valid_in = 0;
    o_valid_in = 0;
  endtask
  initial begin
    #1 preset_full = 1;
    repeat (2) @(posedge clk);
    #2 preset_full = 0;
    @(posedge clk);
    #1;
    check("rst_empty", 32'(o_empty_out), 32'h3);
    check("rst_ready", 32'(i_ready_out), 32'h3);
    check("rst_count", 32'(o_count_out), 0);
    check("rst_flags", 32'({o_overflow_out, o_underflow_out}), 0);
    check("rst_tag", 32'(o_tag_out), 0);
    step(1, 0, 8'h11, 4'd3, 0, 0);
    step(1, 0, 8'h22, 4'd5, 0, 0);
    step(1, 0, 8'h33, 4'd7, 0, 0);
    check("fifo_count0", 32'(o_count_out[3:0]), 3);
    check("fifo_empty", 32'(o_empty_out), 32'h2);
    check("fifo_head_tag", 32'(o_tag_out), 32'h11);
    check("fifo_head_dst", 32'(o_dst_out), 3);
    step(0, 0, 0, 0, 1, 0);
    check("pop1_tag", 32'(o_tag_out), 32'h22);
    check("pop1_dst", 32'(o_dst_out), 5);
    step(0, 0, 0, 0, 1, 0);
    check("pop2_tag", 32'(o_tag_out), 32'h33);
    step(0, 0, 0, 0, 1, 0);
    check("drained_empty0", 32'(o_empty_out[0]), 1);
    check("drained_data", 32'({o_tag_out, o_dst_out, o_vc_out}), 0);
    step(1, 1, 8'hA0, 4'd1, 0, 1);
    step(1, 0, 8'hB0, 4'd2, 0, 1);
    check("ch1_head", 32'(o_tag_out), 32'hA0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0);
    check("two_ch_count", 32'(o_count_out), 0);
    check("two_ch_flags", 32'({o_overflow_out, o_underflow_out}), 0);
    for (int k = 0; k < DEPTH; k++) begin
      step(1, 0, 8'(8'h40 + k), 4'(k), 0, 0);
      if (k == 8) check("ready_at9", 32'(i_ready_out[0]), 1);
      if (k == 9) check("ready_at10", 32'(i_ready_out[0]), 0);
    end
    step(1, 0, 8'hEE, 4'hE, 0, 0);
    check("ovf_count0", 32'(o_count_out[3:0]), 12);
    check("ovf_flag", 32'(o_overflow_out), 1);
    step(1, 0, 8'h4C, 4'hC, 1, 0);
    check("full_swap_count", 32'(o_count_out[3:0]), 12);
    for (int k = 0; k < DEPTH; k++) begin
      check("full_drain_tag", 32'(o_tag_out), 32'(8'h41 + k));
      step(0, 0, 0, 0, 1, 0);
    end
    step(1, 1, 8'd0, 4'd0, 0, 1);
    for (int i = 1; i < 30; i++) begin
      check("wrap_tag", 32'(o_tag_out), 32'(i - 1));
      step(1, 1, 8'(i), 4'(i), 1, 1);
    end
    check("wrap_last", 32'(o_tag_out), 29);
    step(0, 0, 0, 0, 1, 1);
    check("wrap_count1", 32'(o_count_out[7:4]), 0);
    step(0, 0, 0, 0, 1, 1);
    check("unf_flag", 32'(o_underflow_out), 1);
    check("unf_count1", 32'(o_count_out[7:4]), 0);
    step(1, 0, 8'h5A, 4'd9, 1, 0);
    check("empty_pushpop_count", 32'(o_count_out[3:0]), 1);
    check("empty_pushpop_head", 32'(o_tag_out), 32'h5A);
    for (int k = 0; k < 4; k++) step(1, 0, 8'(8'h60 + k), 4'(k), 0, 0);
    for (int k = 0; k < 2; k++) step(1, 1, 8'(8'h70 + k), 4'(k), 0, 0);
    check("pre_rst_counts", 32'(o_count_out), 32'h25);
    @(posedge clk);
    #3 preset_full = 1;
    #1;
    check("arst_count", 32'(o_count_out), 0);
    check("arst_empty", 32'(o_empty_out), 32'h3);
    check("arst_ready", 32'(i_ready_out), 32'h3);
    check("arst_flags", 32'({o_overflow_out, o_underflow_out}), 0);
    check("arst_data", 32'({o_tag_out, o_dst_out, o_vc_out}), 0);
    @(negedge clk);
    #1 preset_full = 0;
    @(posedge clk);
    #1;
    step(1, 0, 8'h77, 4'd6, 0, 0);
    check("post_rst_head", 32'(o_tag_out), 32'h77);
    check("post_rst_dst", 32'(o_dst_out), 6);
    for (int n = 0; n < 3000; n++) begin
      int pr;
      pr = (n % 600) < 300 ? 65 : 35;
      i_valid_in = $urandom_range(99) < pr;
      i_ch_in    = CH_W'($urandom_range(NUM_CH - 1));
      i_tag_in   = 8'($urandom);
      i_dst_in   = 4'($urandom);
      i_vc_in    = 1'($urandom);
      o_valid_in = $urandom_range(99) < 100 - pr;
      o_rd_ch_in = CH_W'($urandom_range(NUM_CH - 1));
      @(posedge clk);
      #1;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
